// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled one-shot down-counter timer (auto-reload under TIMER_AUTORELOAD_EN)
module timer_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             irq
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic             en_q, en_d, ie_q, ie_d, reload_q, reload_d, pend_q, pend_d;
   logic [7:0]       pre_q, pre_d, psc_q, psc_d;
   logic [WIDTH-1:0] load_q, load_d, count_q, count_d;
   logic             wr_ctrl, wr_load, wr_stat, stop, tick, busy, unused_ok;
   always_comb begin
      wr_ctrl   = we && addr == 2'd0;
      wr_load   = we && addr == 2'd1;
      wr_stat   = we && addr == 2'd3;
      stop      = wr_ctrl && !wdata[0];
      tick      = state_q == RUN && psc_q == pre_q;
      busy      = state_q == LOAD || state_q == RUN;
      unused_ok = ^wdata;
      en_d      = wr_ctrl ? wdata[0] : en_q;
      ie_d      = wr_ctrl ? wdata[1] : ie_q;
`ifdef TIMER_AUTORELOAD_EN
      reload_d  = wr_ctrl ? wdata[2] : reload_q;
`else
      reload_d  = 1'b0;
`endif
      pre_d     = wr_ctrl ? wdata[15:8] : pre_q;
      load_d    = wr_load ? wdata : load_q;
      state_d   = state_q;
      count_d   = count_q;
      psc_d     = psc_q;
      // an expiry on the same edge as a W1C re-sets pend below
      pend_d    = pend_q && !(wr_stat && wdata[0]);
      if (stop) state_d = IDLE;
      else begin
         case (state_q)
            IDLE: state_d = wr_ctrl ? LOAD : IDLE;
            LOAD: begin
               count_d = load_q;
               psc_d   = '0;
               state_d = load_q == '0 ? DONE : RUN;
               pend_d  = pend_d || load_q == '0;
            end
            RUN: begin
               psc_d   = tick ? 8'd0 : psc_q + 8'd1;
               count_d = tick && count_q != '0 ? count_q - WIDTH'(1) : count_q;
               state_d = tick && count_q == WIDTH'(1) ? DONE : RUN;
               pend_d  = pend_d || (tick && count_q == WIDTH'(1));
            end
            default: begin
               count_d = '0;
               state_d = reload_q ? LOAD : DONE;
            end
         endcase
      end
      rdata = addr == 2'd0 ? WIDTH'({pre_q, 5'd0, reload_q, ie_q, en_q}) :
              addr == 2'd1 ? load_q :
              addr == 2'd2 ? count_q : WIDTH'({busy, pend_q});
      irq   = pend_q && ie_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         en_q     <= 1'b0;
         ie_q     <= 1'b0;
         reload_q <= 1'b0;
         pend_q   <= 1'b0;
         pre_q    <= '0;
         psc_q    <= '0;
         load_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         ie_q     <= ie_d;
         reload_q <= reload_d;
         pend_q   <= pend_d;
         pre_q    <= pre_d;
         psc_q    <= psc_d;
         load_q   <= load_d;
         count_q  <= count_d;
      end
   end
endmodule
